qerv_fetch: RTL and testbench

Instruction fetch unit between the PC control stage and decode in the qerv core. It takes the current PC from the control stage and issues Wishbone classic read cycles on the instruction bus. It reassembles 32-bit instructions that straddle a word boundary at halfword-aligned PCs. It keeps a one-word buffer so consecutive compressed instructions in the same word need no extra bus cycle.

---
 rtl/qerv_fetch.sv | 150 +++++++++++++++
 tb/tb_qerv_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_fetch.sv
// Instruction fetch: Wishbone classic reads, halfword-straddle reassembly, one-word buffer for compressed pairs.
// Latency: buffer hit 1 cycle; miss = ack + 1; straddle = second ack + 1. All outputs registered.
// Backpressure: waits indefinitely on i_wb_ack with cyc held; i_flush aborts, i_fetch outside IDLE is ignored.
module qerv_fetch #(
  parameter int WITH_C = 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_fetch,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_insn,
  output logic        o_iscomp,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  localparam bit HAS_C = (WITH_C != 0);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

  state_t      state;
  logic [31:0] buf_word;
  logic [29:0] buf_adr;
  logic        buf_vld;

  logic [29:0] pc_word;
  logic [29:0] next_word;
  logic        pc_half;
  logic        unused_pc0;

  logic        buf_hit;
  logic        buf_hi_wide;
  logic        hit_full;
  logic        hit_straddle;
  logic        rdt_straddle;
  logic [31:0] hit_insn;
  logic [31:0] rdt_insn;
  logic [31:0] join_insn;

  // Pick the instruction at halfword h out of a fetched word; without C support the word is passed through.
  function automatic logic [31:0] select_insn(input logic [31:0] w, input logic h);
    if (!HAS_C)
      return w;
    if (h)
      return {16'b0, w[31:16]};
    if (w[1:0] == 2'b11)
      return w;
    return {16'b0, w[15:0]};
  endfunction

  function automatic logic is_comp(input logic [31:0] insn);
    return HAS_C && (insn[1:0] != 2'b11);
  endfunction

  // Word address arithmetic wraps naturally in 30 bits, so PC 0xFFFFFFFE continues at word 0.
  assign pc_word    = i_pc[31:2];
  assign next_word  = pc_word + 30'd1;
  assign pc_half    = HAS_C ? i_pc[1] : 1'b0;
  assign unused_pc0 = i_pc[0];

  // A 32-bit instruction starting in the upper half needs the next word as well.
  assign buf_hit      = HAS_C && buf_vld && (buf_adr == pc_word);
  assign buf_hi_wide  = (buf_word[17:16] == 2'b11);
  assign hit_full     = buf_hit && (!pc_half || !buf_hi_wide);
  assign hit_straddle = buf_hit && pc_half && buf_hi_wide;
  assign rdt_straddle = pc_half && (i_wb_rdt[17:16] == 2'b11);
  assign hit_insn     = select_insn(buf_word, pc_half);
  assign rdt_insn     = select_insn(i_wb_rdt, pc_half);
  // Upper half comes from the buffer as it stood before this edge's refill.
  assign join_insn    = {i_wb_rdt[15:0], buf_word[31:16]};

  // Fetch FSM, buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_wb_cyc <= 1'b0;
      o_wb_adr <= 32'd0;
      o_valid  <= 1'b0;
      o_insn   <= 32'd0;
      o_iscomp <= 1'b0;
      buf_vld  <= 1'b0;
      buf_word <= 32'd0;
      buf_adr  <= 30'd0;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        state    <= IDLE;
        o_wb_cyc <= 1'b0;
        buf_vld  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_fetch) begin
              if (hit_full) begin
                o_valid  <= 1'b1;
                o_insn   <= hit_insn;
                o_iscomp <= is_comp(hit_insn);
              end else if (hit_straddle) begin
                state    <= FETCH1;
                o_wb_cyc <= 1'b1;
                o_wb_adr <= {next_word, 2'b00};
              end else begin
                state    <= FETCH0;
                o_wb_cyc <= 1'b1;
                o_wb_adr <= {pc_word, 2'b00};
              end
            end
          end
          FETCH0: begin
            if (i_wb_ack) begin
              buf_word <= i_wb_rdt;
              buf_adr  <= pc_word;
              buf_vld  <= HAS_C;
              if (rdt_straddle) begin
                state    <= FETCH1;
                o_wb_adr <= {next_word, 2'b00};
              end else begin
                state    <= IDLE;
                o_wb_cyc <= 1'b0;
                o_valid  <= 1'b1;
                o_insn   <= rdt_insn;
                o_iscomp <= is_comp(rdt_insn);
              end
            end
          end
          FETCH1: begin
            if (i_wb_ack) begin
              state    <= IDLE;
              o_wb_cyc <= 1'b0;
              o_valid  <= 1'b1;
              o_insn   <= join_insn;
              o_iscomp <= is_comp(join_insn);
              buf_word <= i_wb_rdt;
              buf_adr  <= next_word;
            end
          end
          default: begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qerv_fetch.sv
// Directed bench for qerv_fetch: hand-computed vectors per scenario.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// The bus slave is played inline by each scenario.
module tb_qerv_fetch;

  logic        clk;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic        i_fetch;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_insn;
  logic        o_iscomp;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  int n_vec = 0;
  int n_err = 0;

  qerv_fetch #(.WITH_C(1)) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_pc     (i_pc),
    .i_fetch  (i_fetch),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_insn   (o_insn),
    .o_iscomp (o_iscomp),
    .o_wb_adr (o_wb_adr),
    .o_wb_cyc (o_wb_cyc),
    .i_wb_rdt (i_wb_rdt),
    .i_wb_ack (i_wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle fetch request; returns at the falling edge after the sampling edge T.
  task automatic pulse_fetch(input logic [31:0] pc);
    i_pc    = pc;
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
  endtask

  // Play the bus slave for one read: wait (bounded) for cyc, stall 'delay' cycles, ack with data.
  // Returns at the falling edge after the ack edge.
  task automatic serve(input logic [31:0] data, input int delay,
                       output logic [31:0] adr, output bit ok);
    int n;
    n   = 0;
    ok  = 1'b0;
    adr = 32'd0;
    while (!o_wb_cyc && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (o_wb_cyc) begin
      adr = o_wb_adr;
      repeat (delay) @(negedge clk);
      i_wb_ack = 1'b1;
      i_wb_rdt = data;
      @(negedge clk);
      i_wb_ack = 1'b0;
      ok       = 1'b1;
    end
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_pc     = 32'd0;
    i_fetch  = 1'b0;
    i_flush  = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_rdt = 32'd0;
    repeat (3) @(negedge clk);
    n_vec++; if (o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %b want 0", o_wb_cyc); end
    n_vec++; if (o_wb_adr !== 32'd0) begin n_err++; $display("FAIL reset_adr: got %h want 0", o_wb_adr); end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_vec++; if (o_insn !== 32'd0) begin n_err++; $display("FAIL reset_insn: got %h want 0", o_insn); end
    n_vec++; if (o_iscomp !== 1'b0) begin n_err++; $display("FAIL reset_iscomp: got %b want 0", o_iscomp); end
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned_miss();
    logic [31:0] adr;
    bit          ok;
    pulse_fetch(32'h0000_0100);
    serve(32'h00A0_0093, 2, adr, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL aligned_bus: got no cyc want cyc"); end
    n_vec++; if (adr !== 32'h0000_0100) begin n_err++; $display("FAIL aligned_adr: got %h want %h", adr, 32'h0000_0100); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL aligned_valid: got %b want 1", o_valid); end
    n_vec++; if (o_insn !== 32'h00A0_0093) begin n_err++; $display("FAIL aligned_insn: got %h want %h", o_insn, 32'h00A0_0093); end
    n_vec++; if (o_iscomp !== 1'b0) begin n_err++; $display("FAIL aligned_iscomp: got %b want 0", o_iscomp); end
    n_vec++; if (o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL aligned_cyc_drop: got %b want 0", o_wb_cyc); end
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL aligned_valid_pulse: got %b want 0", o_valid); end
    n_vec++; if (o_insn !== 32'h00A0_0093) begin n_err++; $display("FAIL aligned_insn_hold: got %h want %h", o_insn, 32'h00A0_0093); end
  endtask

  task automatic test_compressed_pair();
    logic [31:0] adr;
    bit          ok;
    pulse_fetch(32'h0000_0200);
    serve(32'h4501_4485, 0, adr, ok);
    n_vec++; if (!ok || adr !== 32'h0000_0200) begin n_err++; $display("FAIL pair_first_adr: got %h ok=%0d want %h", adr, ok, 32'h0000_0200); end
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h0000_4485) begin n_err++; $display("FAIL pair_first_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h0000_4485); end
    n_vec++; if (o_iscomp !== 1'b1) begin n_err++; $display("FAIL pair_first_iscomp: got %b want 1", o_iscomp); end
    @(negedge clk);
    pulse_fetch(32'h0000_0202);
    n_vec++; if (o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL pair_hit_nocyc: got %b want 0", o_wb_cyc); end
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h0000_4501) begin n_err++; $display("FAIL pair_hit_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h0000_4501); end
    n_vec++; if (o_iscomp !== 1'b1) begin n_err++; $display("FAIL pair_hit_iscomp: got %b want 1", o_iscomp); end
    @(negedge clk);
  endtask

  task automatic test_straddle();
    logic [31:0] adr;
    bit          ok;
    pulse_fetch(32'h0000_0302);
    serve(32'h0093_4501, 1, adr, ok);
    n_vec++; if (!ok || adr !== 32'h0000_0300) begin n_err++; $display("FAIL strad_adr0: got %h ok=%0d want %h", adr, ok, 32'h0000_0300); end
    n_vec++; if (o_wb_cyc !== 1'b1 || o_valid !== 1'b0) begin n_err++; $display("FAIL strad_cyc_held: got cyc=%b v=%b want cyc=1 v=0", o_wb_cyc, o_valid); end
    n_vec++; if (o_wb_adr !== 32'h0000_0304) begin n_err++; $display("FAIL strad_adr1: got %h want %h", o_wb_adr, 32'h0000_0304); end
    serve(32'hFFFF_00A0, 0, adr, ok);
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h00A0_0093) begin n_err++; $display("FAIL strad_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h00A0_0093); end
    n_vec++; if (o_iscomp !== 1'b0 || o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL strad_done: got comp=%b cyc=%b want 0 0", o_iscomp, o_wb_cyc); end
    @(negedge clk);
    // Buffered word 0x304 has a 32-bit upper half: only the following word is read.
    pulse_fetch(32'h0000_0306);
    n_vec++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h0000_0308) begin n_err++; $display("FAIL hitstrad_adr: got cyc=%b %h want cyc=1 %h", o_wb_cyc, o_wb_adr, 32'h0000_0308); end
    serve(32'h1234_5678, 0, adr, ok);
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h5678_FFFF) begin n_err++; $display("FAIL hitstrad_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h5678_FFFF); end
    @(negedge clk);
    pulse_fetch(32'h0000_030A);
    n_vec++; if (o_wb_cyc !== 1'b0 || o_valid !== 1'b1) begin n_err++; $display("FAIL hithi_timing: got cyc=%b v=%b want cyc=0 v=1", o_wb_cyc, o_valid); end
    n_vec++; if (o_insn !== 32'h0000_1234 || o_iscomp !== 1'b1) begin n_err++; $display("FAIL hithi_insn: got %h comp=%b want %h comp=1", o_insn, o_iscomp, 32'h0000_1234); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] adr;
    bit          ok;
    pulse_fetch(32'hFFFF_FFFE);
    serve(32'h0093_0001, 0, adr, ok);
    n_vec++; if (!ok || adr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_adr0: got %h ok=%0d want %h", adr, ok, 32'hFFFF_FFFC); end
    serve(32'h0000_00A0, 0, adr, ok);
    n_vec++; if (!ok || adr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_adr1: got %h ok=%0d want %h", adr, ok, 32'h0000_0000); end
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h00A0_0093) begin n_err++; $display("FAIL wrap_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h00A0_0093); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] adr;
    bit          ok;
    int          n;
    pulse_fetch(32'h0000_0400);
    serve(32'h0000_0001, 0, adr, ok);
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h0000_0001) begin n_err++; $display("FAIL flush_prefill: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h0000_0001); end
    @(negedge clk);
    pulse_fetch(32'h0000_0500);
    n = 0;
    while (!o_wb_cyc && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++; if (o_wb_cyc !== 1'b1) begin n_err++; $display("FAIL flush_cyc_start: got %b want 1", o_wb_cyc); end
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_0013;
    i_flush  = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    i_flush  = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL flush_ack_drop: got v=%b cyc=%b want 0 0", o_valid, o_wb_cyc); end
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_late_valid: got %b want 0", o_valid); end
    // Word 0x400 would have hit before the flush.
    pulse_fetch(32'h0000_0402);
    n_vec++; if (o_wb_cyc !== 1'b1 || o_valid !== 1'b0 || o_wb_adr !== 32'h0000_0400) begin n_err++; $display("FAIL flush_refetch: got cyc=%b v=%b %h want cyc=1 v=0 %h", o_wb_cyc, o_valid, o_wb_adr, 32'h0000_0400); end
    serve(32'h0001_0001, 0, adr, ok);
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h0000_0001 || o_iscomp !== 1'b1) begin n_err++; $display("FAIL flush_refetch_insn: got v=%b %h comp=%b want v=1 %h comp=1", o_valid, o_insn, o_iscomp, 32'h0000_0001); end
    @(negedge clk);
    // Flush wins over a simultaneous fetch that would hit.
    i_pc    = 32'h0000_0400;
    i_fetch = 1'b1;
    i_flush = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    i_flush = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL flush_prio: got v=%b cyc=%b want 0 0", o_valid, o_wb_cyc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch1();
    logic [31:0] adr;
    bit          ok;
    pulse_fetch(32'h0000_0602);
    serve(32'h0093_0000, 0, adr, ok);
    n_vec++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h0000_0604) begin n_err++; $display("FAIL rstmid_in_fetch1: got cyc=%b %h want cyc=1 %h", o_wb_cyc, o_wb_adr, 32'h0000_0604); end
    i_rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (o_wb_cyc !== 1'b0 || o_wb_adr !== 32'd0) begin n_err++; $display("FAIL rstmid_bus: got cyc=%b %h want cyc=0 0", o_wb_cyc, o_wb_adr); end
    n_vec++; if (o_valid !== 1'b0 || o_insn !== 32'd0 || o_iscomp !== 1'b0) begin n_err++; $display("FAIL rstmid_outs: got v=%b %h comp=%b want 0 0 0", o_valid, o_insn, o_iscomp); end
    i_rst_n  = 1'b1;
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_00A0;
    @(negedge clk);
    i_wb_ack = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL rstmid_late_ack: got v=%b cyc=%b want 0 0", o_valid, o_wb_cyc); end
    pulse_fetch(32'h0000_0602);
    n_vec++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h0000_0600) begin n_err++; $display("FAIL rstmid_refetch: got cyc=%b %h want cyc=1 %h", o_wb_cyc, o_wb_adr, 32'h0000_0600); end
    serve(32'h0093_0000, 0, adr, ok);
    serve(32'h0000_00A0, 0, adr, ok);
    n_vec++; if (o_valid !== 1'b1 || o_insn !== 32'h00A0_0093) begin n_err++; $display("FAIL rstmid_refetch_insn: got v=%b %h want v=1 %h", o_valid, o_insn, 32'h00A0_0093); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned_miss();
    test_compressed_pair();
    test_straddle();
    test_wrap();
    test_flush();
    test_reset_mid_fetch1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
